noc_packet_injector: RTL
========================

// Module: noc_packet_injector
// PURPOSE
//   Network-interface transmit side for the mesh. Takes a destination address and a stream of
//   payload words from the local core, and emits HEAD/BODY/TAIL flits into the router's local port.
//   It produces the {y,x} dest field that the router's per-port decoders consume; every flit
//   carries a 2-bit type tag.
// PARAMETERS
//   NOC_WIDTH   4   mesh columns; X_W = $clog2(NOC_WIDTH)
//   NOC_LENGTH  4   mesh rows;    Y_W = $clog2(NOC_LENGTH); ADDR_W = X_W + Y_W
//   ROUTER_ID   0   flat id of attached router; own addr = {ROUTER_ID/NOC_WIDTH, ROUTER_ID%NOC_WIDTH}
//   DATA_WIDTH  32  payload bits per flit; must be >= 2*ADDR_W+8 (elaboration $error otherwise)
//   PKT_LEN     4   payload flits per packet (>=1); last one is TAIL
// PORTS
//   clk         in   1             clock, all logic on rising edge
//   rst_n       in   1             asynchronous, active-low reset
//   in_valid    in   1             core offers dest (IDLE) or payload word (BODY)
//   in_ready    out  1             payload word accepted when in_valid&in_ready
//   in_dest     in   ADDR_W        {y,x} destination; sampled only when the head flit is loaded
//   in_data     in   DATA_WIDTH    payload word
//   flit_valid  out  1             flit_out valid toward router local input
//   flit_ready  in   1             router accepts flit when flit_valid&flit_ready
//   flit_out    out  DATA_WIDTH+2  [DATA_WIDTH+1:DATA_WIDTH]=type (01 HEAD, 10 BODY, 11 TAIL); rest=payload
//   busy        out  1             (state!=IDLE) | flit_valid
//   err_dest    out  1             sticky: a dest with x>=NOC_WIDTH or y>=NOC_LENGTH was sent
// BEHAVIOUR
//   Reset: state=IDLE, flit_valid=0, flit_out=0, cnt=0, err_dest=0, busy=0, in_ready=0, seq=0.
//     Reset mid-packet drops the partial packet; the router-side recovery is out of scope.
//   Output reg: out_free = !flit_valid | flit_ready. Loading occurs only when out_free.
//     flit_out and flit_valid stay stable while flit_valid & !flit_ready.
//   FSM IDLE:
//     - in_ready=0.
//     - If in_valid & out_free: load HEAD, latch in_dest, cnt<=0, ->BODY.
//     - HEAD payload: [ADDR_W-1:0]=dest, [2*ADDR_W-1:ADDR_W]=own addr, remaining bits 0.
//     - in_data is NOT consumed by the head.
//   FSM BODY:
//     - in_ready = out_free (combinational from flit_ready).
//     - On accept: load payload=in_data. Type is TAIL if cnt==PKT_LEN-1 (then ->IDLE, cnt<=0);
//       otherwise BODY, cnt++.
//   If neither a load nor a drain occurs, flit_valid holds. On drain without a load, flit_valid<=0.
//   Latency: accepted word appears on flit_out next cycle.
//   Throughput: 1 flit/cycle with flit_ready=1; a packet occupies PKT_LEN+1 consecutive cycles.
//   Back-to-back: a TAIL load and the next HEAD load may occur on consecutive cycles (no bubble).
//   PKT_LEN=1: the single payload flit is TAIL; cnt never increments.
//   Dest == own addr: sent normally. Out-of-range dest: still sent unmodified; err_dest<=1 when
//     its HEAD loads; cleared only by reset.
//   in_dest changes while in BODY are ignored.
// CONFIGURATION
//   NI_SEQNUM_EN defined:
//     - 8-bit seq placed in HEAD payload [2*ADDR_W+7:2*ADDR_W].
//     - seq increments on every HEAD load, wraps 255->0.
//   NI_SEQNUM_EN undefined:
//     - Those bits are 0 and no counter exists.
// TESTING
//   1 Reset; ROUTER_ID=5, in_dest=4'b1011, words A,B,C,D, flit_ready=1 ->
//       flits HEAD(payload 0x5B), BODY A, BODY B, BODY C, TAIL D on 5 consecutive cycles;
//       busy falls the cycle after TAIL drains.
//   2 As 1, but flit_ready=0 for 3 cycles after HEAD ->
//       HEAD held stable; in_ready=0 during the stall; A appears the cycle after flit_ready rises;
//       no word lost or duplicated.
//   3 Two packets back-to-back, in_valid held ->
//       TAIL of pkt1 is immediately followed by HEAD of pkt2;
//       with NI_SEQNUM_EN, seq fields read 0 then 1; after 256 packets seq reads 0 again.
//   4 NOC_WIDTH=3, in_dest x=3 ->
//       packet emitted unchanged; err_dest=1 the cycle after HEAD loads; stays 1 across later good packets.
//   5 Assert rst_n low after BODY B is loaded ->
//       flit_valid=0 and busy=0 immediately (async); after release a new packet starts with a clean HEAD.
//   6 PKT_LEN=1 build, one word X -> HEAD then TAIL X; FSM is back in IDLE after 2 flits.

Source files
------------

// File: rtl/noc_packet_injector_if.sv
// Core-to-injector payload handshake and injector-to-router flit handshake.
// The injector connects through the slave modport; the core/router side uses master.
interface noc_packet_injector_if #(
  parameter int ADDR_W     = 4,
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_W-1:0]     in_dest;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  flit_valid;
  logic                  flit_ready;
  logic [DATA_WIDTH+1:0] flit_out;

  modport master (
    output in_valid, in_dest, in_data, flit_ready,
    input  in_ready, flit_valid, flit_out
  );

  modport slave (
    input  in_valid, in_dest, in_data, flit_ready,
    output in_ready, flit_valid, flit_out
  );
endinterface

// File: rtl/noc_packet_injector.sv
// NI transmit side: emits a HEAD flit ({own addr, dest}) followed by PKT_LEN payload flits, last one TAIL.
// Optional macro NI_SEQNUM_EN adds an 8-bit per-packet sequence number to the HEAD payload.
module noc_packet_injector #(
  parameter int NOC_WIDTH  = 4,
  parameter int NOC_LENGTH = 4,
  parameter int ROUTER_ID  = 0,
  parameter int DATA_WIDTH = 32,
  parameter int PKT_LEN    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  noc_packet_injector_if.slave   bus,
  output logic                   busy,
  output logic                   err_dest
);
  localparam int X_W    = $clog2(NOC_WIDTH);
  localparam int Y_W    = $clog2(NOC_LENGTH);
  localparam int ADDR_W = X_W + Y_W;
  localparam int CNT_W  = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PKT_LEN - 1);
  localparam logic [X_W-1:0]   OWN_X    = X_W'(ROUTER_ID % NOC_WIDTH);
  localparam logic [Y_W-1:0]   OWN_Y    = Y_W'(ROUTER_ID / NOC_WIDTH);

  localparam logic [1:0] TYPE_HEAD = 2'b01;
  localparam logic [1:0] TYPE_BODY = 2'b10;
  localparam logic [1:0] TYPE_TAIL = 2'b11;

  if (DATA_WIDTH < 2*ADDR_W + 8) begin : g_width_check
    $error("noc_packet_injector: DATA_WIDTH must be >= 2*ADDR_W+8");
  end
  if (PKT_LEN < 1) begin : g_len_check
    $error("noc_packet_injector: PKT_LEN must be >= 1");
  end

  typedef enum logic {IDLE = 1'b0, BODY = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  out_free;
  logic                  load, load_head;
  logic [1:0]            load_type;
  logic [DATA_WIDTH-1:0] load_payload;
  logic [DATA_WIDTH-1:0] head_payload;
  logic                  flit_valid_q;
  logic [DATA_WIDTH+1:0] flit_q;
  logic [X_W-1:0]        dest_x;
  logic [Y_W-1:0]        dest_y;
  logic                  dest_bad;

  assign out_free = !flit_valid_q || bus.flit_ready;

  assign dest_x   = bus.in_dest[X_W-1:0];
  assign dest_y   = bus.in_dest[ADDR_W-1:X_W];
  assign dest_bad = (32'(dest_x) >= 32'(NOC_WIDTH)) || (32'(dest_y) >= 32'(NOC_LENGTH));

`ifdef NI_SEQNUM_EN
  logic [7:0] seq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq <= 8'd0;
    end else if (load_head) begin
      seq <= seq + 8'd1;
    end
  end
`endif

  always_comb begin
    head_payload                    = '0;
    head_payload[ADDR_W-1:0]        = bus.in_dest;
    head_payload[2*ADDR_W-1:ADDR_W] = {OWN_Y, OWN_X};
`ifdef NI_SEQNUM_EN
    head_payload[2*ADDR_W+7:2*ADDR_W] = seq;
`endif
  end

  // The head consumes only the destination; in_data is taken from the first BODY beat onwards.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    load         = 1'b0;
    load_head    = 1'b0;
    load_type    = TYPE_HEAD;
    load_payload = head_payload;
    case (state)
      IDLE: begin
        if (bus.in_valid && out_free) begin
          load      = 1'b1;
          load_head = 1'b1;
          cnt_nxt   = '0;
          state_nxt = BODY;
        end
      end
      BODY: begin
        if (bus.in_valid && out_free) begin
          load         = 1'b1;
          load_payload = bus.in_data;
          if (cnt == CNT_LAST) begin
            load_type = TYPE_TAIL;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            load_type = TYPE_BODY;
            cnt_nxt   = cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Output register: holds its flit until the router takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flit_valid_q <= 1'b0;
      flit_q       <= '0;
      err_dest     <= 1'b0;
    end else begin
      if (load) begin
        flit_valid_q <= 1'b1;
        flit_q       <= {load_type, load_payload};
      end else if (bus.flit_ready) begin
        flit_valid_q <= 1'b0;
      end
      if (load_head && dest_bad) begin
        err_dest <= 1'b1;
      end
    end
  end

  assign bus.in_ready   = (state == BODY) && out_free;
  assign bus.flit_valid = flit_valid_q;
  assign bus.flit_out   = flit_q;
  assign busy           = (state != IDLE) || flit_valid_q;
endmodule
